load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU: takes the ALU-computed effective address plus rs2 data and funct3, performs the RV32I load/store on a valid/ready data-memory port, and returns the formatted load result toward writeback.
- Handles byte/half/word alignment, write strobes, sign/zero extension and misalignment detection.
- Stalls the core while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, cycles allowed in REQ or RSP before aborting with error; 0 disables the timeout.
- CNT_WIDTH, 8, width of the timeout counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a memory instruction
- req_ready  out  1  unit accepts a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- req_addr  in  32  effective address (ALU result)
- req_wdata  in  32  rs2 store data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_error  out  1  misaligned, illegal funct3, bus error or timeout; valid with rsp_valid
- stall  out  1  core must hold its pipeline
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_write  out  1  store request
- mem_addr  out  32  word-aligned address, {req_addr[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables; 0000 for loads
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data word
- mem_err  in  1  bus error; sampled with mem_rvalid (loads) or mem_valid&mem_ready (stores)

Behaviour:
- Reset (rst_n low, async): state IDLE, counter 0, all request/data registers 0. All outputs 0, except req_ready = 1 while in IDLE.
- IDLE: req_ready = 1.
  - On req_valid: latch write, funct3, addr and wdata.
  - Check alignment and funct3:
    - H/HU: addr[0] must be 0.
    - W: addr[1:0] must be 00.
    - Load funct3 011/110/111 is illegal.
    - Store funct3 other than 000/001/010 is illegal.
  - Fault -> go to DONE with error flag set; no memory transaction is issued.
  - Otherwise -> go to REQ.
- REQ: mem_valid = 1; address, data, strobe and write held stable until mem_ready.
  - On mem_ready, store: go to DONE; error = mem_err.
  - On mem_ready, load: go to RSP.
- RSP: wait for mem_rvalid.
  - On mem_rvalid: capture the extended data and error = mem_err; go to DONE.
  - If mem_err is set, the data is forced to 0.
- DONE: rsp_valid = 1 and req_ready = 0 for exactly one cycle, then go to IDLE. A back-to-back request is accepted the following cycle.
- stall = (IDLE & req_valid) | REQ | RSP. stall is 0 in DONE so the core advances on the rsp_valid cycle.
- Store formatting:
  - SB: wdata = {4{wdata[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{wdata[15:0]}}, wstrb = 0011 or 1100 by addr[1].
  - SW: wdata = wdata, wstrb = 1111.
- Load extraction:
  - Lane = mem_rdata >> (8*addr[1:0]).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word unchanged.
- Timeout: the counter clears on entry to REQ/RSP and increments each cycle in those states. On reaching TIMEOUT_CYCLES -> DONE with error=1 and rdata=0; the memory transaction is abandoned.
- Zero-wait memory latency from accept to rsp_valid: store 2 cycles, load 3 cycles.
- mem_ready and mem_rvalid arriving in the same cycle in REQ: only mem_ready is honoured. The memory must present rvalid in a later cycle.
- Reset asserted mid-transaction: immediate return to IDLE; an outstanding memory access is dropped without a response.

Decomposition:
- lsu_pkg holds:
  - The state enum (IDLE, REQ, RSP, DONE).
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - A misalignment-check function.
- Sub-module lsu_align (combinational) contains store lane replication/strobe generation and load extraction/extension. The FSM, counters and registers stay in load_store_unit.

Test Plan:
- SB: addr=0x1003, wdata=0x000000A5, zero-wait memory -> mem_addr=0x1000, mem_wdata=0xA5A5A5A5, mem_wstrb=1000; rsp_valid 2 cycles after accept, rsp_error=0.
- LB: addr=0x2002, mem_rdata=0x1280FF34 -> rsp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x2002 -> 0x00001280.
- LW: addr=0x3002 -> no mem_valid ever; rsp_valid 1 cycle after accept with rsp_error=1 and rsp_rdata=0. Load funct3=011 gives the same response.
- LW: memory holds mem_ready low 5 cycles, then rvalid 3 cycles later with 0xDEADBEEF -> stall high throughout, mem_* stable, rsp_rdata=0xDEADBEEF.
- TIMEOUT_CYCLES=4, mem_ready never asserted -> rsp_valid with rsp_error=1 after 4 REQ cycles. mem_err=1 on a store ack -> rsp_error=1.
- rst_n pulled low while in RSP -> outputs immediately 0, req_ready=1. A new LW afterwards completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and access-legality helpers for the RV32I load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic bad;
    case (funct3)
      F3_H, F3_HU: bad = offset[0];
      F3_W:        bad = |offset;
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic illegal_funct3(input logic write, input logic [2:0] funct3);
    logic bad;
    case (funct3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = write;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data formatting: store lane replication and byte strobes,
// load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] lane_data,
  output logic [3:0]  strobe,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  assign shifted = load_word >> {offset, 3'b000};

  always_comb begin
    lane_data = store_data;
    strobe    = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        lane_data = {4{store_data[7:0]}};
        strobe    = 4'b0001 << offset;
      end
      2'b01: begin
        lane_data = {2{store_data[15:0]}};
        strobe    = offset[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_data = store_data;
        strobe    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    load_data = 32'd0;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = load_word;
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one outstanding load/store on a valid/ready data port,
// with alignment checks, timeout abort and a one-cycle completion pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        stall,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  lsu_state_e           state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 write_reg;
  logic [2:0]           funct3_reg;
  logic [31:0]          addr_reg;
  logic [31:0]          wdata_reg;
  logic [31:0]          rdata_reg, rdata_next;
  logic                 error_reg, error_next;

  logic                 accept;
  logic                 fault;
  logic                 timeout_hit;
  logic [31:0]          lane_data;
  logic [3:0]           strobe;
  logic [31:0]          load_data;

  lsu_align u_align (
    .funct3     (funct3_reg),
    .offset     (addr_reg[1:0]),
    .store_data (wdata_reg),
    .load_word  (mem_rdata),
    .lane_data  (lane_data),
    .strobe     (strobe),
    .load_data  (load_data)
  );

  assign accept      = (state_reg == S_IDLE) && req_valid;
  assign fault       = misaligned(req_funct3, req_addr[1:0]) || illegal_funct3(req_write, req_funct3);
  // A zero TIMEOUT_CYCLES disables the abort path entirely.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    error_next = error_reg;
    rdata_next = rdata_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          rdata_next = 32'd0;
          cnt_next   = '0;
          error_next = fault;
          state_next = fault ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          cnt_next = '0;
          if (write_reg) begin
            error_next = mem_err;
            state_next = S_DONE;
          end else begin
            state_next = S_RSP;
          end
        end else if (timeout_hit) begin
          error_next = 1'b1;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_RSP: begin
        if (mem_rvalid) begin
          error_next = mem_err;
          rdata_next = mem_err ? 32'd0 : load_data;
          state_next = S_DONE;
        end else if (timeout_hit) begin
          error_next = 1'b1;
          rdata_next = 32'd0;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      write_reg  <= 1'b0;
      funct3_reg <= 3'd0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      rdata_reg  <= 32'd0;
      error_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
      error_reg <= error_next;
      if (accept) begin
        write_reg  <= req_write;
        funct3_reg <= req_funct3;
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
      end
    end
  end

  assign req_ready = (state_reg == S_IDLE);
  assign rsp_valid = (state_reg == S_DONE);
  assign rsp_rdata = (state_reg == S_DONE) ? rdata_reg : 32'd0;
  assign rsp_error = (state_reg == S_DONE) && error_reg;
  assign stall     = accept || (state_reg == S_REQ) || (state_reg == S_RSP);

  assign mem_valid = (state_reg == S_REQ);
  assign mem_write = write_reg;
  assign mem_addr  = {addr_reg[31:2], 2'b00};
  assign mem_wdata = lane_data;
  assign mem_wstrb = write_reg ? strobe : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: a byte-array reference model predicts
// responses, a reactive memory responder drives the data port, a monitor checks each rsp_valid.
module tb_load_store_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        stall;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_err = 1'b0;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .stall      (stall),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0]  ref_mem [64];
  logic [31:0] mem_words [16];

  int          ready_dly = 0, rvalid_dly = 0;
  bit          no_ready = 0, no_rvalid = 0, inj_err = 0, dual = 0;
  logic        exp_write = 1'b0;
  logic [31:0] exp_maddr = 32'd0, exp_mwdata = 32'd0;
  logic [3:0]  exp_wstrb = 4'd0;
  int unsigned accept_cyc = 0;
  int          rsp_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [5:0] a);
    int size;
    logic [31:0] v;
    size = 1 << f3[1:0];
    v = 32'd0;
    for (int k = 0; k < size; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8 * size)) - 1);
    return v;
  endfunction

  task automatic set_word(input int idx, input logic [31:0] val);
    mem_words[idx] = val;
    for (int k = 0; k < 4; k++) ref_mem[idx*4 + k] = val[8*k +: 8];
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit err, input int rdly, input int vdly,
                       input bit nrdy, input bit nrv, input bit dl, input bit wait_rsp);
    int   size;
    int   off;
    int   n;
    int   target;
    bit   legal;
    exp_t e;
    size  = 1 << f3[1:0];
    off   = int'(addr[1:0]);
    legal = w ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    if (!legal || (addr % size) != 0) begin
      e = '{32'd0, 1'b1, 1};
    end else if (nrdy) begin
      e = '{32'd0, 1'b1, 1 + TO};
    end else if (!w && nrv) begin
      e = '{32'd0, 1'b1, 2 + rdly + TO};
    end else if (w) begin
      for (int k = 0; k < size; k++) ref_mem[int'(addr[5:0]) + k] = wd[8*k +: 8];
      e = '{32'd0, err, 2 + rdly};
    end else begin
      e = '{err ? 32'd0 : load_val(f3, addr[5:0]), err, 3 + rdly + vdly};
    end
    exp_write = w;
    exp_maddr = {addr[31:2], 2'b00};
    for (int l = 0; l < 4; l++) begin
      exp_wstrb[l] = w && (l >= off) && (l < off + size);
      exp_mwdata[8*l +: 8] = wd[8*(l % size) +: 8];
    end
    ready_dly = rdly; rvalid_dly = vdly; no_ready = nrdy; no_rvalid = nrv;
    inj_err = err; dual = dl;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_wait: got 0 expected 1");
    end
    target = rsp_count + 1;
    exp_q.push_back(e);
    accept_cyc = cyc;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = $urandom_range(0, 1); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (wait_rsp) begin
      n = 0;
      while (rsp_count < target && n < 4 * TO + 40) begin
        @(negedge clk);
        n++;
      end
      if (rsp_count < target) begin
        checks++; errors++;
        $display("FAIL rsp_wait: got no rsp_valid expected one within %0d cycles", n);
      end
      $display("txn w=%0d f3=%0d addr=%08h wdata=%08h exp_rdata=%08h exp_err=%0d lat=%0d",
               w, f3, addr, wd, e.rdata, e.err, e.lat);
    end
  endtask

  // Reactive data-memory model; idle-cycle noise on mem_err/mem_rdata must be ignored by the DUT.
  initial begin
    int phase;
    int wcnt;
    int ld_idx;
    phase = 0; wcnt = 0; ld_idx = 0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      mem_err = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      if (!rst_n) begin
        phase = 0; wcnt = 0;
      end else if (phase == 0) begin
        if (mem_valid && !no_ready) begin
          if (wcnt >= ready_dly) begin
            mem_ready = 1'b1;
            if (exp_write) mem_err = inj_err;
            chk("mem_addr", mem_addr, exp_maddr);
            chk("mem_write", 32'(mem_write), 32'(exp_write));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
            if (exp_write) begin
              chk("mem_wdata", mem_wdata, exp_mwdata);
              for (int l = 0; l < 4; l++)
                if (mem_wstrb[l]) mem_words[mem_addr[5:2]][8*l +: 8] = mem_wdata[8*l +: 8];
            end else begin
              phase = 1;
              ld_idx = int'(mem_addr[5:2]);
              if (dual) begin
                mem_rvalid = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
              end
            end
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          wcnt = 0;
        end
      end else begin
        if (no_rvalid) begin
          phase = 0;
        end else if (wcnt >= rvalid_dly) begin
          mem_rvalid = 1'b1;
          mem_rdata = mem_words[ld_idx];
          mem_err = inj_err;
          phase = 0; wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every completion pulse and watches stall / request hold.
  initial begin
    logic        pv;
    logic [31:0] p_addr, p_wdata;
    logic [4:0]  p_ctl;
    exp_t        e;
    pv = 1'b0; p_addr = 32'd0; p_wdata = 32'd0; p_ctl = 5'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && !mem_ready && mem_valid) begin
          chk("hold_addr", mem_addr, p_addr);
          chk("hold_wdata", mem_wdata, p_wdata);
          chk("hold_ctl", 32'({mem_write, mem_wstrb}), 32'(p_ctl));
        end
        pv = mem_valid; p_addr = mem_addr; p_wdata = mem_wdata; p_ctl = {mem_write, mem_wstrb};
        if (rsp_valid) begin
          rsp_count++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: got rsp_valid expected none");
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_error", 32'(rsp_error), 32'(e.err));
            chk("latency", cyc - accept_cyc, 32'(e.lat));
            chk("stall_done", 32'(stall), 32'd0);
            chk("ready_done", 32'(req_ready), 32'd0);
          end
        end else if (exp_q.size() > 0 && cyc > accept_cyc) begin
          chk("stall_busy", 32'(stall), 32'd1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);

    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 0, 0, 0, 0, 1);
    set_word(0, 32'h1280_FF34);
    issue(1'b0, 3'b000, 32'h0000_2002, 32'd0, 0, 0, 0, 0, 0, 0, 1);
    issue(1'b0, 3'b100, 32'h0000_2002, 32'd0, 0, 0, 0, 0, 0, 0, 1);
    issue(1'b0, 3'b101, 32'h0000_2002, 32'd0, 0, 0, 0, 0, 0, 1, 1);
    issue(1'b0, 3'b010, 32'h0000_3002, 32'd0, 0, 0, 0, 0, 0, 0, 1);
    issue(1'b0, 3'b011, 32'h0000_3000, 32'd0, 0, 0, 0, 0, 0, 0, 1);
    set_word(4, 32'hDEAD_BEEF);
    issue(1'b0, 3'b010, 32'h0000_4010, 32'd0, 0, 5, 3, 0, 0, 0, 1);
    issue(1'b1, 3'b010, 32'h0000_5020, 32'h1234_5678, 0, 0, 0, 1, 0, 0, 1);
    issue(1'b0, 3'b001, 32'h0000_5022, 32'd0, 0, 0, 0, 0, 1, 0, 1);
    issue(1'b1, 3'b001, 32'h0000_6006, 32'hCAFE_F00D, 1, 0, 0, 0, 0, 0, 1);
    issue(1'b0, 3'b010, 32'h0000_6004, 32'd0, 1, 1, 1, 0, 0, 0, 1);

    // Reset while a load is waiting in RSP
    issue(1'b0, 3'b010, 32'h0000_7008, 32'd0, 0, 0, 6, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 3'b010, 32'h0000_7008, 32'd0, 0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 160; i++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        if (w) f3 = 3'($urandom_range(0, 2));
        else   f3 = ($urandom_range(0, 4) > 2) ? 3'($urandom_range(4, 5)) : 3'($urandom_range(0, 2));
      end else begin
        f3 = 3'($urandom);
      end
      a = $urandom;
      issue(w, f3, a, $urandom, ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : 0,
            ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : 0,
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 3) == 0), 1);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover: got %0d pending responses expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
